lt24_system_nios2_ocimem_arbiter: RTL and testbench

Sequences all accesses to the Nios II on-chip-instrumentation (OCI) debug RAM and arbitrates between its two requesters: the JTAG debug module's system-clock side (already synchronised command strobes) and the CPU's Avalon debug slave. The block owns the single-port RAM's address, write and data pins. It also handles the one-cycle RAM read latency, JTAG address auto-increment and Avalon waitrequest generation. It sits between the debug-module sysclk logic and the OCI RAM instance, entirely in the `clk` domain.

---
 rtl/lt24_system_nios2_ocimem_arbiter.sv | 98 +++++++++
 tb/tb_lt24_system_nios2_ocimem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_system_nios2_ocimem_arbiter.sv
// lt24_system_nios2_ocimem_arbiter: sequences JTAG and Avalon debug-slave accesses onto the single-port OCI RAM.
module lt24_system_nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_addr_ld,
    input  logic [ADDR_W-1:0] jtag_addr_in,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_busy,
    output logic              jtag_ovf,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
    state_t state, state_nx;
    logic owner, op_wr, last_owner, jtag_pend, jtag_pwr;
    logic [DATA_W-1:0] jtag_pwdata;
    logic [ADDR_W-1:0] jtag_ptr;
    logic av_req, grant_j, grant_a, grant, drop, jtag_resp, wr_sel;

    // owner/last_owner: 1 = JTAG, 0 = Avalon; the side not served last wins a tie
    always_comb begin
        av_req    = av_read | av_write;
        grant_j   = (state == IDLE) & jtag_pend & (~av_req | ~last_owner);
        grant_a   = (state == IDLE) & av_req & (~jtag_pend | last_owner);
        grant     = grant_j | grant_a;
        wr_sel    = grant_j ? jtag_pwr : av_write;
        drop      = jtag_req & jtag_pend & ~grant_j;
        jtag_resp = (state == RESP) & owner;
    end

    always_comb begin
        state_nx = (state == IDLE)    ? (grant ? ACCESS : IDLE) :
                   (state == ACCESS)  ? (op_wr ? RESP : CAPTURE) :
                   (state == CAPTURE) ? RESP : IDLE;
    end

    always_comb begin
        av_waitrequest = ~((state == RESP) & ~owner);
        jtag_busy      = jtag_pend | ((state != IDLE) & owner);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            op_wr       <= 1'b0;
            last_owner  <= 1'b1;
            jtag_pend   <= 1'b0;
            jtag_pwr    <= 1'b0;
            jtag_pwdata <= '0;
            jtag_ovf    <= 1'b0;
            jtag_ptr    <= '0;
            jtag_done   <= 1'b0;
            jtag_rdata  <= '0;
            av_readdata <= '0;
            ram_addr    <= '0;
            ram_wren    <= 1'b0;
            ram_wdata   <= '0;
        end else begin
            state     <= state_nx;
            ram_wren  <= grant & wr_sel;
            jtag_done <= (state_nx == RESP) & owner;
            if (grant) begin
                ram_addr   <= grant_j ? jtag_ptr : av_address;
                ram_wdata  <= grant_j ? jtag_pwdata : av_writedata;
                owner      <= grant_j;
                op_wr      <= wr_sel;
                last_owner <= grant_j;
            end
            if (state == CAPTURE && owner)
                jtag_rdata <= ram_rdata;
            if (state == CAPTURE && !owner)
                av_readdata <= ram_rdata;
            jtag_pend <= (jtag_pend & ~grant_j) | jtag_req;
            if (jtag_req && !drop) begin
                jtag_pwr    <= jtag_wr;
                jtag_pwdata <= jtag_wdata;
            end
            jtag_ovf <= (jtag_ovf & ~jtag_addr_ld) | drop;
            jtag_ptr <= jtag_addr_ld ? jtag_addr_in : jtag_resp ? jtag_ptr + ADDR_W'(1) : jtag_ptr;
        end
    end
endmodule

// File: tb/tb_lt24_system_nios2_ocimem_arbiter.sv
// tb_lt24_system_nios2_ocimem_arbiter: directed checks of the OCI RAM arbiter against a behavioural RAM.
module tb_lt24_system_nios2_ocimem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        jtag_addr_ld, jtag_req, jtag_wr;
    logic [7:0]  jtag_addr_in, av_address, ram_addr;
    logic [31:0] jtag_wdata, jtag_rdata, av_writedata, av_readdata, ram_wdata, ram_rdata;
    logic        jtag_done, jtag_busy, jtag_ovf, av_read, av_write, av_waitrequest, ram_wren;
    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    lt24_system_nios2_ocimem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_addr_ld(jtag_addr_ld), .jtag_addr_in(jtag_addr_in),
        .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .jtag_rdata(jtag_rdata), .jtag_done(jtag_done), .jtag_busy(jtag_busy), .jtag_ovf(jtag_ovf),
        .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic jtag_write(input logic [31:0] d, input logic [7:0] a);
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = d;
        cyc();
        jtag_req = 1'b0;
        chk("jw_busy", {31'b0, jtag_busy}, 32'd1);
        cyc();
        chk("jw_addr", {24'b0, ram_addr}, {24'b0, a});
        chk("jw_wren", {31'b0, ram_wren}, 32'd1);
        chk("jw_wdata", ram_wdata, d);
        cyc();
        chk("jw_done", {31'b0, jtag_done}, 32'd1);
        cyc();
        chk("jw_done_off", {31'b0, jtag_done}, 32'd0);
        chk("jw_busy_off", {31'b0, jtag_busy}, 32'd0);
    endtask

    task automatic jtag_read(input logic [7:0] a, input logic [31:0] d);
        jtag_req = 1'b1; jtag_wr = 1'b0;
        cyc();
        jtag_req = 1'b0;
        cyc();
        chk("jr_addr", {24'b0, ram_addr}, {24'b0, a});
        chk("jr_wren", {31'b0, ram_wren}, 32'd0);
        cyc();
        chk("jr_nodone", {31'b0, jtag_done}, 32'd0);
        cyc();
        chk("jr_done", {31'b0, jtag_done}, 32'd1);
        chk("jr_rdata", jtag_rdata, d);
        cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        jtag_addr_ld = 0; jtag_addr_in = 0; jtag_req = 0; jtag_wr = 0; jtag_wdata = 0;
        av_address = 0; av_read = 0; av_write = 0; av_writedata = 0;
        cyc(); cyc();
        chk("rst_wait", {31'b0, av_waitrequest}, 32'd1);
        chk("rst_wren", {31'b0, ram_wren}, 32'd0);
        chk("rst_done", {31'b0, jtag_done}, 32'd0);
        chk("rst_busy", {31'b0, jtag_busy}, 32'd0);
        chk("rst_addr", {24'b0, ram_addr}, 32'd0);
        reset_n = 1'b1;
        cyc();
        // Avalon write 0x10 <- DEADBEEF
        av_write = 1; av_address = 8'h10; av_writedata = 32'hDEADBEEF;
        chk("avw_c0_wait", {31'b0, av_waitrequest}, 32'd1);
        cyc();
        chk("avw_c1_wren", {31'b0, ram_wren}, 32'd1);
        chk("avw_c1_addr", {24'b0, ram_addr}, 32'h10);
        chk("avw_c1_wdata", ram_wdata, 32'hDEADBEEF);
        chk("avw_c1_wait", {31'b0, av_waitrequest}, 32'd1);
        cyc();
        chk("avw_c2_wait", {31'b0, av_waitrequest}, 32'd0);
        chk("avw_c2_wren", {31'b0, ram_wren}, 32'd0);
        av_write = 0;
        cyc();
        // Avalon read 0x10
        av_read = 1;
        cyc();
        chk("avr_c1_addr", {24'b0, ram_addr}, 32'h10);
        chk("avr_c1_wren", {31'b0, ram_wren}, 32'd0);
        cyc();
        chk("avr_c2_wait", {31'b0, av_waitrequest}, 32'd1);
        cyc();
        chk("avr_c3_wait", {31'b0, av_waitrequest}, 32'd0);
        chk("avr_c3_data", av_readdata, 32'hDEADBEEF);
        av_read = 0;
        cyc();
        // JTAG auto-increment across the wrap
        jtag_addr_ld = 1; jtag_addr_in = 8'hFE;
        cyc();
        jtag_addr_ld = 0;
        jtag_write(32'h1, 8'hFE);
        jtag_write(32'h2, 8'hFF);
        jtag_write(32'h3, 8'h00);
        jtag_addr_ld = 1; jtag_addr_in = 8'hFE;
        cyc();
        jtag_addr_ld = 0;
        jtag_read(8'hFE, 32'h1);
        jtag_read(8'hFF, 32'h2);
        jtag_read(8'h00, 32'h3);
        // reset in the middle of an Avalon read
        av_read = 1; av_address = 8'h10;
        cyc(); cyc();
        reset_n = 1'b0;
        #1;
        chk("mid_wait", {31'b0, av_waitrequest}, 32'd1);
        chk("mid_wren", {31'b0, ram_wren}, 32'd0);
        chk("mid_done", {31'b0, jtag_done}, 32'd0);
        chk("mid_avdata", av_readdata, 32'd0);
        chk("mid_jdata", jtag_rdata, 32'd0);
        chk("mid_addr", {24'b0, ram_addr}, 32'd0);
        chk("mid_wdata", ram_wdata, 32'd0);
        av_read = 0;
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_wait", {31'b0, av_waitrequest}, 32'd1);
            chk("post_rst_done", {31'b0, jtag_done}, 32'd0);
        end
        // tie out of reset: Avalon first, then JTAG from pointer 0
        jtag_req = 1; jtag_wr = 0;
        cyc();
        jtag_req = 0; av_read = 1; av_address = 8'h10;
        cyc();
        chk("tie1_av_addr", {24'b0, ram_addr}, 32'h10);
        chk("tie1_busy", {31'b0, jtag_busy}, 32'd1);
        cyc(); cyc();
        chk("tie1_av_wait", {31'b0, av_waitrequest}, 32'd0);
        chk("tie1_av_data", av_readdata, 32'hDEADBEEF);
        chk("tie1_nodone", {31'b0, jtag_done}, 32'd0);
        av_read = 0;
        cyc();
        chk("tie1_jbusy", {31'b0, jtag_busy}, 32'd1);
        cyc();
        chk("tie1_j_addr", {24'b0, ram_addr}, 32'h00);
        cyc(); cyc();
        chk("tie1_j_done", {31'b0, jtag_done}, 32'd1);
        chk("tie1_j_data", jtag_rdata, 32'h3);
        cyc();
        // Avalon alone makes it last owner, so the next tie goes to JTAG
        av_write = 1; av_address = 8'h20; av_writedata = 32'h12345678;
        cyc(); cyc();
        chk("avw2_wait", {31'b0, av_waitrequest}, 32'd0);
        av_write = 0;
        cyc();
        jtag_addr_ld = 1; jtag_addr_in = 8'hFF; jtag_req = 1; jtag_wr = 0;
        cyc();
        jtag_addr_ld = 0; jtag_req = 0; av_read = 1; av_address = 8'h20;
        cyc();
        chk("tie2_j_addr", {24'b0, ram_addr}, 32'hFF);
        chk("tie2_av_wait", {31'b0, av_waitrequest}, 32'd1);
        cyc(); cyc();
        chk("tie2_j_done", {31'b0, jtag_done}, 32'd1);
        chk("tie2_j_data", jtag_rdata, 32'h2);
        chk("tie2_av_wait2", {31'b0, av_waitrequest}, 32'd1);
        cyc(); cyc();
        chk("tie2_av_addr", {24'b0, ram_addr}, 32'h20);
        cyc(); cyc();
        chk("tie2_av_resp", {31'b0, av_waitrequest}, 32'd0);
        chk("tie2_av_data", av_readdata, 32'h12345678);
        av_read = 0;
        cyc();
        // overflow: second jtag_req while one is pending is dropped
        av_read = 1; av_address = 8'h10;
        cyc();
        jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'hAA;
        cyc();
        jtag_wdata = 32'hBB;
        cyc();
        jtag_req = 0;
        chk("ovf_set", {31'b0, jtag_ovf}, 32'd1);
        chk("ovf_av_resp", {31'b0, av_waitrequest}, 32'd0);
        av_read = 0;
        cyc(); cyc();
        chk("ovf_addr", {24'b0, ram_addr}, 32'h00);
        chk("ovf_wdata", ram_wdata, 32'hAA);
        chk("ovf_wren", {31'b0, ram_wren}, 32'd1);
        cyc();
        chk("ovf_done", {31'b0, jtag_done}, 32'd1);
        cyc();
        chk("ovf_single", {31'b0, jtag_busy}, 32'd0);
        chk("ovf_sticky", {31'b0, jtag_ovf}, 32'd1);
        jtag_addr_ld = 1; jtag_addr_in = 8'h00;
        cyc();
        jtag_addr_ld = 0;
        chk("ovf_clr", {31'b0, jtag_ovf}, 32'd0);
        // pointer load in the JTAG RESP cycle beats the increment
        jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'h55;
        cyc();
        jtag_req = 0;
        cyc();
        chk("col_addr0", {24'b0, ram_addr}, 32'h00);
        cyc();
        chk("col_done", {31'b0, jtag_done}, 32'd1);
        jtag_addr_ld = 1; jtag_addr_in = 8'h40;
        cyc();
        jtag_addr_ld = 0;
        jtag_write(32'h66, 8'h40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
